// File: rtl/dmem_pkg.sv
// Shared MemOp encodings, arbiter state type and access-decoding helpers
// for the data-memory arbiter.
package dmem_pkg;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;

    function automatic logic is_load_op(input logic [2:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store_op(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [2:0] op_size_bytes(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op_size_bytes(op))
            3'd2:    return addr_lo[0];
            3'd4:    return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and memory-side signals of the data-memory arbiter.
// slave = arbiter side; master = requesters plus the memory's read data.
interface dmem_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       req_write;
    logic [NUM_REQ-1:0]       req_lock;
    logic [NUM_REQ-1:0][2:0]  req_op;
    logic [NUM_REQ-1:0][31:0] req_addr;
    logic [NUM_REQ-1:0][31:0] req_wdata;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic                     rsp_err;
    logic [31:0]              rsp_rdata;
    logic                     mem_read;
    logic                     mem_write;
    logic [2:0]               mem_op;
    logic [31:0]              mem_addr;
    logic [31:0]              mem_wdata;
    logic [31:0]              mem_rdata;

    modport slave (
        input  req_valid, req_write, req_lock, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_read, mem_write, mem_op, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_lock, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_read, mem_write, mem_op, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from
// ptr_i, wrapping modulo N.
module rr_picker #(
    parameter  int unsigned N    = 2,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);
    always_comb begin
        int unsigned j;
        j       = 0;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_i) + k) % N;
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IdxW'(j);
            end
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory among NUM_REQ requesters, with
// access checking, locked sequences and a one-cycle registered response.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0] cand, gnt;
    logic [IdxW-1:0]    gnt_idx;
    logic               gnt_any;

    // While locked, only the owner is visible to the picker.
    always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand[i] = bus.req_valid[i] && ((state_q == ST_IDLE) || (owner_q == IdxW'(i)));
        end
    end

    rr_picker #(.N(NUM_REQ)) u_picker (
        .req_i   (cand),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_any)
    );

    logic        sel_write, sel_lock, acc_err;
    logic [2:0]  sel_op;
    logic [31:0] sel_addr, sel_wdata;
    logic [32:0] last_byte;

    always_comb begin
        sel_write = bus.req_write[gnt_idx];
        sel_lock  = bus.req_lock[gnt_idx];
        sel_op    = bus.req_op[gnt_idx];
        sel_addr  = bus.req_addr[gnt_idx];
        sel_wdata = bus.req_wdata[gnt_idx];
        // 33 bits so an access running past 2^32 is still caught.
        last_byte = {1'b0, sel_addr} + 33'(op_size_bytes(sel_op)) - 33'd1;
        acc_err   = is_misaligned(sel_op, sel_addr[1:0]) ||
                    ((last_byte >> ADDR_WIDTH) != 33'd0) ||
                    (sel_write ? !is_store_op(sel_op) : !is_load_op(sel_op));
    end

    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_op    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt_any && !acc_err) begin
            bus.mem_read  = !sel_write;
            bus.mem_write = sel_write;
            bus.mem_op    = sel_op;
            bus.mem_addr  = sel_addr;
            bus.mem_wdata = sel_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        if (gnt_any) begin
            rsp_valid_d = gnt;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (!acc_err && !sel_write) ? bus.mem_rdata : 32'd0;
            rr_ptr_d    = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (sel_lock) begin
                        state_d = ST_LOCKED;
                        owner_d = gnt_idx;
                    end
                end
                ST_LOCKED: begin
                    if (!sel_lock) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // A waiting request must be held unchanged until it is accepted.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_rules
        a_req_hold: assert property (@(posedge clk) disable iff (reset)
            (bus.req_valid[i] && !bus.req_ready[i]) |=>
                (bus.req_valid[i] && $stable(bus.req_write[i]) && $stable(bus.req_lock[i]) &&
                 $stable(bus.req_op[i]) && $stable(bus.req_addr[i]) &&
                 $stable(bus.req_wdata[i])));
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a little-endian byte
// memory model that extends load data by MemOp.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    dmem_arbiter_if #(.NUM_REQ(2)) bus ();

    dmem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (bus.mem_write) begin
            case (bus.mem_op)
                OP_SB: mem[bus.mem_addr[9:0]] <= bus.mem_wdata[7:0];
                OP_SH: begin
                    mem[bus.mem_addr[9:0]]         <= bus.mem_wdata[7:0];
                    mem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_wdata[15:8];
                end
                default: begin
                    mem[bus.mem_addr[9:0]]         <= bus.mem_wdata[7:0];
                    mem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_wdata[15:8];
                    mem[bus.mem_addr[9:0] + 10'd2] <= bus.mem_wdata[23:16];
                    mem[bus.mem_addr[9:0] + 10'd3] <= bus.mem_wdata[31:24];
                end
            endcase
        end
    end

    always_comb begin
        logic [9:0]  a;
        logic [31:0] w;
        a = bus.mem_addr[9:0];
        w = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
        case (bus.mem_op)
            OP_LB:   bus.mem_rdata = {{24{w[7]}}, w[7:0]};
            OP_LBU:  bus.mem_rdata = {24'd0, w[7:0]};
            OP_LH:   bus.mem_rdata = {{16{w[15]}}, w[15:0]};
            OP_LHU:  bus.mem_rdata = {16'd0, w[15:0]};
            default: bus.mem_rdata = w;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic l,
                           input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid[i] = v;
        bus.req_write[i] = w;
        bus.req_lock[i]  = l;
        bus.req_op[i]    = op;
        bus.req_addr[i]  = a;
        bus.req_wdata[i] = d;
    endtask

    task automatic idle(input int i);
        set_req(i, 1'b0, 1'b0, 1'b0, OP_LB, 32'd0, 32'd0);
    endtask

    task automatic to_neg;
        @(negedge clk);
    endtask

    task automatic to_post;
        @(posedge clk);
        #1;
    endtask

    // Single-requester access: check grant/memory strobes, then the response.
    task automatic one_access(input string tag, input int i, input logic w, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] d, input logic exp_mem,
                              input logic exp_err, input logic [31:0] exp_rdata);
        set_req(i, 1'b1, w, 1'b0, op, a, d);
        to_neg();
        chk({tag, " ready"}, 32'(bus.req_ready), (i == 0) ? 32'd1 : 32'd2);
        chk({tag, " mem_rd"}, 32'(bus.mem_read), 32'(exp_mem && !w));
        chk({tag, " mem_wr"}, 32'(bus.mem_write), 32'(exp_mem && w));
        to_post();
        idle(i);
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), (i == 0) ? 32'd1 : 32'd2);
        chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        chk({tag, " rsp_rdata"}, bus.rsp_rdata, exp_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle(0);
        idle(1);
        #1 reset = 1'b1;
        #11;
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset ready", 32'(bus.req_ready), 32'd0);
        chk("reset mem_rd", 32'(bus.mem_read), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Store then load back through requester 0; rr_ptr ends at 1.
        set_req(0, 1'b1, 1'b1, 1'b0, OP_SW, 32'h10, 32'hDEADBEEF);
        to_neg();
        chk("sw ready", 32'(bus.req_ready), 32'd1);
        chk("sw mem_wr", 32'(bus.mem_write), 32'd1);
        chk("sw mem_op", 32'(bus.mem_op), 32'(OP_SW));
        chk("sw mem_addr", bus.mem_addr, 32'h10);
        chk("sw mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        to_post();
        chk("sw rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("sw rsp_rdata", bus.rsp_rdata, 32'd0);
        idle(0);
        one_access("lw0", 0, 1'b0, OP_LW, 32'h10, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);
        // Requester 1 alone: returns rr_ptr to 0.
        one_access("lw1", 1, 1'b0, OP_LW, 32'h10, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);

        // Both requesters valid: alternating grants starting at 0.
        set_req(0, 1'b1, 1'b0, 1'b0, OP_LW, 32'h10, 32'd0);
        set_req(1, 1'b1, 1'b0, 1'b0, OP_LW, 32'h10, 32'd0);
        for (int k = 0; k < 4; k++) begin
            to_neg();
            chk($sformatf("rr%0d ready", k), 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            to_post();
            chk($sformatf("rr%0d rsp_valid", k), 32'(bus.rsp_valid),
                (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr%0d rsp_rdata", k), bus.rsp_rdata, 32'hDEADBEEF);
        end
        idle(1);
        to_neg();
        chk("rr4 ready", 32'(bus.req_ready), 32'd1);
        to_post();
        idle(0);

        // Rejected accesses: misaligned, out of range, wrong direction.
        one_access("lh mis", 1, 1'b0, OP_LH, 32'h21, 32'd0, 1'b0, 1'b1, 32'd0);
        one_access("sw mis", 1, 1'b1, OP_SW, 32'h102, 32'h1, 1'b0, 1'b1, 32'd0);
        one_access("lw oor", 1, 1'b0, OP_LW, 32'h400, 32'd0, 1'b0, 1'b1, 32'd0);
        one_access("lw top", 1, 1'b0, OP_LW, 32'h3FC, 32'd0, 1'b1, 1'b0, 32'd0);
        one_access("dir", 1, 1'b1, OP_LW, 32'h10, 32'h5, 1'b0, 1'b1, 32'd0);

        // Byte store and sign/zero-extended loads.
        one_access("sb", 0, 1'b1, OP_SB, 32'h30, 32'h80, 1'b1, 1'b0, 32'd0);
        one_access("lb", 0, 1'b0, OP_LB, 32'h30, 32'd0, 1'b1, 1'b0, 32'hFFFFFF80);
        one_access("lbu", 0, 1'b0, OP_LBU, 32'h30, 32'd0, 1'b1, 1'b0, 32'h00000080);

        // Locked read-modify-write by requester 1 holds off requester 0.
        set_req(0, 1'b1, 1'b0, 1'b0, OP_LW, 32'h10, 32'd0);
        set_req(1, 1'b1, 1'b0, 1'b1, OP_LW, 32'h40, 32'd0);
        to_neg();
        chk("lock ready", 32'(bus.req_ready), 32'd2);
        to_post();
        idle(1);
        to_neg();
        chk("locked wait ready", 32'(bus.req_ready), 32'd0);
        to_post();
        chk("locked wait rsp", 32'(bus.rsp_valid), 32'd0);
        set_req(1, 1'b1, 1'b1, 1'b0, OP_SW, 32'h40, 32'h12345678);
        to_neg();
        chk("unlock ready", 32'(bus.req_ready), 32'd2);
        chk("unlock mem_wr", 32'(bus.mem_write), 32'd1);
        to_post();
        idle(1);
        chk("unlock rsp_valid", 32'(bus.rsp_valid), 32'd2);
        to_neg();
        chk("after unlock ready", 32'(bus.req_ready), 32'd1);
        to_post();
        idle(0);
        chk("after unlock rdata", bus.rsp_rdata, 32'hDEADBEEF);

        // Reset while locked with a response pending.
        set_req(1, 1'b1, 1'b0, 1'b1, OP_LW, 32'h40, 32'd0);
        to_neg();
        chk("relock ready", 32'(bus.req_ready), 32'd2);
        to_post();
        chk("relock rsp_valid", 32'(bus.rsp_valid), 32'd2);
        chk("relock rdata", bus.rsp_rdata, 32'h12345678);
        idle(1);
        reset = 1'b1;
        #1;
        chk("mid reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid reset rdata", bus.rsp_rdata, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, OP_LW, 32'h10, 32'd0);
        set_req(1, 1'b1, 1'b0, 1'b0, OP_LW, 32'h40, 32'd0);
        to_neg();
        chk("post reset ready", 32'(bus.req_ready), 32'd1);
        to_post();
        idle(0);
        chk("post reset rsp", 32'(bus.rsp_valid), 32'd1);
        to_neg();
        chk("post reset ready1", 32'(bus.req_ready), 32'd2);
        to_post();
        idle(1);
        chk("post reset rdata1", bus.rsp_rdata, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
